// File: rtl/timer_unit.sv
// Programmable 32-bit down-counter timer with a memory-mapped register window.
// An irq is raised when the count expires; one-shot or auto-reload operation.
module timer_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  state_t      state;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic        ctrl_en;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  offset;
  logic        ctrl_write;
  logic        preset_write;
  logic        unused_addr_bits;

  // The bridge has already matched the window, so only the word offset matters.
  assign offset           = addr[1:0];
  assign unused_addr_bits = ^addr[29:2];
  assign ctrl_write       = we && (offset == OFS_CTRL);
  assign preset_write     = we && (offset == OFS_PRESET);

  // A CPU write to CTRL or PRESET stalls the counter for that cycle; otherwise
  // the FSM takes exactly one step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ctrl_im   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_en   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else if (ctrl_write) begin
      ctrl_im   <= din[3];
      ctrl_mode <= din[2:1];
      ctrl_en   <= din[0];
      irq_flag  <= 1'b0;
    end else if (preset_write) begin
      preset <= din;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          // Auto-reload leaves EN set so IDLE immediately starts the next run.
          if (ctrl_mode == MODE_AUTO) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl_en <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dout = 32'd0;
    case (offset)
      OFS_CTRL:   dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      OFS_PRESET: dout = preset;
      OFS_COUNT:  dout = count;
      default:    dout = 32'd0;
    endcase
  end

  assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_unit.sv
// Directed testbench for timer_unit: a phase-based reference model is compared
// against dout and irq every cycle, alongside hand-computed literal checks.
module tb_timer_unit;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  timer_unit dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is a sequence of numbered phases counted in
  // non-write cycles. Phase 1 loads, phase 2 shows the loaded value, each later
  // phase is one lower, and expiry lands on phase max(L,1)+2.
  logic        m_en;
  logic        m_im;
  logic [1:0]  m_mode;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  longint      m_phase;
  longint      m_load;

  always @(posedge clk or negedge reset) begin : model
    longint exp_ph;
    longint np;
    if (!reset) begin
      m_en     <= 1'b0;
      m_im     <= 1'b0;
      m_mode   <= 2'b00;
      m_preset <= 32'd0;
      m_count  <= 32'd0;
      m_flag   <= 1'b0;
      m_phase  <= 0;
      m_load   <= 0;
    end else if (we && addr[1:0] == 2'd0) begin
      m_en   <= din[0];
      m_mode <= din[2:1];
      m_im   <= din[3];
      m_flag <= 1'b0;
    end else if (we && addr[1:0] == 2'd1) begin
      m_preset <= din;
    end else begin
      exp_ph = ((m_load > 1) ? m_load : 1) + 2;
      if (m_phase == 0) begin
        if (m_en) m_phase <= 1;
      end else if (m_phase == 1) begin
        m_load  <= longint'(m_preset);
        m_count <= m_preset;
        m_phase <= 2;
      end else if (m_phase == exp_ph) begin
        if (m_mode == 2'b01) m_flag <= 1'b0;
        else m_en <= 1'b0;
        m_phase <= 0;
      end else if (!m_en) begin
        m_phase <= 0;
      end else begin
        np = m_phase + 1;
        m_phase <= np;
        if (np == exp_ph) begin
          m_count <= 32'd0;
          m_flag  <= 1'b1;
        end else begin
          m_count <= 32'(m_load - (np - 2));
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      checkOutput("model_dout", dout, model_read(addr[1:0]));
      checkOutput("model_irq", {31'd0, irq}, {31'd0, m_im & m_flag});
    end
  end

  // Drives one bus cycle captured at the next rising edge; returns 1 ns after it.
  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
    we   = w;
    addr = {28'd0, a};
    din  = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, input string name, input logic [31:0] expected);
    addr = {28'd0, a};
    #1;
    checkOutput(name, dout, expected);
  endtask

  task automatic check_irq(input string name, input logic expected);
    checkOutput(name, {31'd0, irq}, {31'd0, expected});
  endtask

  task automatic quiesce();
    applyStimulus(1'b1, 2'd0, 32'd0);
    step(3);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 30'd0;
    din   = 32'd0;
    #2;
    peek(2'd0, "reset_ctrl", 32'd0);
    peek(2'd2, "reset_count", 32'd0);
    check_irq("reset_irq", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1);

    $display("[TB] one-shot, PRESET=5");
    applyStimulus(1'b1, 2'd1, 32'd5);
    applyStimulus(1'b1, 2'd0, 32'h9);
    for (int k = 2; k <= 6; k++) begin
      step(k == 2 ? 2 : 1);
      peek(2'd2, "oneshot_count", 32'(7 - k));
      check_irq("oneshot_irq_low", 1'b0);
    end
    step(1);
    check_irq("oneshot_irq_e7", 1'b1);
    peek(2'd2, "oneshot_count_e7", 32'd0);
    step(1);
    peek(2'd0, "oneshot_ctrl_e8", 32'h8);
    step(5);
    check_irq("oneshot_irq_held", 1'b1);
    applyStimulus(1'b1, 2'd0, 32'h8);
    check_irq("oneshot_irq_cleared", 1'b0);
    quiesce();

    $display("[TB] auto-reload, PRESET=5");
    applyStimulus(1'b1, 2'd0, 32'hB);
    step(7);
    check_irq("auto_irq_e7", 1'b1);
    step(1);
    check_irq("auto_irq_e8", 1'b0);
    step(2);
    peek(2'd2, "auto_count_e10", 32'd5);
    step(4);
    check_irq("auto_irq_e14", 1'b0);
    step(1);
    check_irq("auto_irq_e15", 1'b1);
    step(1);
    check_irq("auto_irq_e16", 1'b0);
    step(7);
    check_irq("auto_irq_e23", 1'b1);
    quiesce();

    $display("[TB] boundary presets 0 and 1");
    for (int p = 0; p <= 1; p++) begin
      applyStimulus(1'b1, 2'd1, 32'(p));
      applyStimulus(1'b1, 2'd0, 32'h9);
      step(2);
      check_irq("boundary_irq_e2", 1'b0);
      peek(2'd2, "boundary_count_e2", 32'(p));
      step(1);
      check_irq("boundary_irq_e3", 1'b1);
      peek(2'd2, "boundary_count_e3", 32'd0);
      quiesce();
    end

    $display("[TB] write priority and pause");
    applyStimulus(1'b1, 2'd1, 32'd10);
    applyStimulus(1'b1, 2'd0, 32'h1);
    step(4);
    peek(2'd2, "prio_count_e4", 32'd8);
    applyStimulus(1'b1, 2'd1, 32'd100);
    peek(2'd2, "prio_count_held", 32'd8);
    step(1);
    peek(2'd2, "prio_count_next", 32'd7);
    applyStimulus(1'b1, 2'd0, 32'h0);
    step(2);
    peek(2'd2, "pause_count_frozen", 32'd7);
    applyStimulus(1'b1, 2'd0, 32'h9);
    step(2);
    peek(2'd2, "prio_new_preset", 32'd100);
    quiesce();

    $display("[TB] masking");
    applyStimulus(1'b1, 2'd1, 32'd2);
    applyStimulus(1'b1, 2'd0, 32'h1);
    step(4);
    peek(2'd2, "mask_count_e4", 32'd0);
    check_irq("mask_irq_masked", 1'b0);
    applyStimulus(1'b1, 2'd0, 32'h8);
    check_irq("mask_irq_after_ctrl", 1'b0);
    quiesce();

    $display("[TB] decode");
    applyStimulus(1'b1, 2'd1, 32'd10);
    applyStimulus(1'b1, 2'd0, 32'h1);
    step(3);
    peek(2'd2, "decode_count_e3", 32'd9);
    applyStimulus(1'b1, 2'd2, 32'h0000FFFF);
    peek(2'd2, "decode_count_wr2", 32'd8);
    applyStimulus(1'b1, 2'd3, 32'hFFFFFFFF);
    peek(2'd3, "decode_read3", 32'd0);
    peek(2'd2, "decode_count_wr3", 32'd7);
    applyStimulus(1'b1, 2'd0, 32'hFFFFFFFF);
    peek(2'd0, "decode_ctrl_ones", 32'h0000000F);
    quiesce();

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 2'd1, 32'd9);
    applyStimulus(1'b1, 2'd0, 32'h9);
    step(4);
    peek(2'd2, "rst_count_before", 32'd7);
    reset = 1'b0;
    peek(2'd2, "rst_count_async", 32'd0);
    peek(2'd0, "rst_ctrl_async", 32'd0);
    check_irq("rst_irq_async", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(4);
    peek(2'd2, "rst_count_idle", 32'd0);
    peek(2'd1, "rst_preset", 32'd0);
    check_irq("rst_irq_idle", 1'b0);

    step(1);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Programmable down-counter peripheral mapped behind the system bridge at one of the timer windows (0x7f00–0x7f0b or 0x7f10–0x7f1b).
- Consumes the bridge's address, write data and single-bit write enable. Returns read data to the bridge read mux.
- Raises an interrupt request toward the CPU's external interrupt inputs when the count expires.
- Two identical instances (T0, T1) sit side by side downstream of the bridge.

Parameters:
- none (all widths fixed at 32 bits)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- addr  input  30  word address from bridge, A_out[31:2]; only addr[1:0] decoded (window decode done by bridge)
- we  input  1  write enable from bridge (asserted only for full-word stores inside this window)
- din  input  32  write data from bridge
- dout  output  32  combinational read data for the register selected by addr[1:0]
- irq  output  1  interrupt request = CTRL.IM & irq_flag

Behaviour:
- Register map, selected by addr[1:0]:
  - 0 CTRL: bit3 IM, bits2:1 MODE, bit0 EN. Bits 31:4 are not stored and read 0.
  - 1 PRESET: 32-bit reload value.
  - 2 COUNT: read-only; writes ignored.
  - 3 reserved: reads 0; writes ignored.
- Reset (reset=0, immediate, independent of clk):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - irq=0 and dout reflects the zeroed registers.
  - Reset mid-count abandons the count with no residual irq.
- Write cycle (we=1, offset 0 or 1):
  - Target register updated at the edge.
  - FSM holds state and COUNT for that cycle (CPU write has priority; no count step).
  - A write to CTRL also clears irq_flag.
  - A write to offset 2 or 3 is treated as a no-write cycle; the FSM advances normally.
- FSM (one transition per non-write cycle):
  - IDLE: if EN -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - if !EN -> IDLE (COUNT frozen).
    - else if COUNT>1 -> COUNT<=COUNT-1.
    - else (COUNT is 0 or 1) -> COUNT<=0, irq_flag<=1, -> INT.
  - INT:
    - MODE=00 (one-shot): EN<=0, irq_flag held, -> IDLE.
    - MODE=01 (auto-reload): irq_flag<=0, -> IDLE; IDLE then reloads because EN is still 1.
    - MODE=1x: behaves as 00.
- Timing, with EN written at edge E0 and PRESET=N≥2:
  - LOAD at E1; COUNT=N at E2.
  - COUNT reaches 1 at E(N+1).
  - irq_flag=1 at E(N+2).
  - Mode 01: irq pulse is exactly one cycle and repeats every N+3 cycles.
- PRESET=0 and PRESET=1 both expire on the first CNT cycle (flag set at E3).
- irq is combinational from registers.
  - Clearing IM masks irq without clearing irq_flag.
  - Setting IM later exposes a pending flag.
- dout is purely combinational; a read has no side effects.

Test Plan:
- Reset: drive reset=0 mid-count (COUNT=7, EN=1) -> same cycle COUNT=0, CTRL=0, irq=0; FSM IDLE after release; no counting until EN rewritten.
- One-shot: PRESET=5, CTRL=0x9 at E0 -> COUNT reads 5,4,3,2,1 at E2..E6; irq=1 from E7; CTRL reads 0x8 after E8; irq stays 1 until a CTRL write clears it.
- Auto-reload: PRESET=5, CTRL=0xB at E0 -> irq high only in the cycle after E7, after E15 and after E23; COUNT=5 again at E10.
- Boundary presets: PRESET=0 and PRESET=1 with CTRL=0x9 -> irq=1 at E3; COUNT reads 0.
- Write priority and pause:
  - Write PRESET=100 while counting -> that cycle COUNT unchanged; next decrement continues from the old value; new PRESET used on the next LOAD.
  - Write CTRL.EN=0 -> COUNT frozen, FSM IDLE.
- Masking and decode:
  - CTRL=0x1 (IM=0) run to expiry -> irq=0 while flag set; then write CTRL=0x8 -> irq=0 (write cleared flag).
  - Write 0xFFFF to offset 2 -> COUNT unaffected.
  - Read offset 3 -> 0.
  - Read CTRL after writing 0xFFFFFFFF -> 0x0000000F.
